// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and default timing.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int DEF_PLL_RESET_CYCLES    = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 256;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_RESET_HOLD_CYCLES   = 64;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop bit synchroniser; both stages clear to 0 on asynchronous reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, qualifies the synchronised lock with retry on timeout,
// and releases the active-high system reset once lock has been stable.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RESET_CYCLES    = DEF_PLL_RESET_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int RESET_HOLD_CYCLES   = DEF_RESET_HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       force_relock,
    output logic       pll_resetb,
    output logic       sys_reset,
    output logic       pll_ready,
    output logic       lock_lost,
    output logic [3:0] retry_count,
    output logic [1:0] seq_state
);

    localparam int RST_W = $clog2(PLL_RESET_CYCLES + 1);
    localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TMO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int HLD_W = $clog2(RESET_HOLD_CYCLES + 1);

    logic             lock_s;
    seq_state_t       state_r, state_s;
    logic [RST_W-1:0] rst_cnt_r, rst_cnt_s;
    logic [STB_W-1:0] stable_cnt_r, stable_cnt_s;
    logic [TMO_W-1:0] tout_cnt_r, tout_cnt_s;
    logic [HLD_W-1:0] hold_cnt_r, hold_cnt_s;
    logic             lock_lost_s;
    logic [3:0]       retry_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // Next-state, counter and sticky-status logic.
    // rst_cnt_r holds the number of low cycles already driven on pll_resetb; the entry edge
    // drives it low, so every other state preloads 1, while the reset interval itself counts 0.
    always_comb begin
        state_s      = state_r;
        rst_cnt_s    = RST_W'(1);
        stable_cnt_s = '0;
        tout_cnt_s   = '0;
        hold_cnt_s   = '0;
        lock_lost_s  = lock_lost;
        retry_s      = retry_count;
        case (state_r)
            PLL_RST: begin
                if (rst_cnt_r == RST_W'(PLL_RESET_CYCLES)) begin
                    state_s   = WAIT_LOCK;
                    rst_cnt_s = '0;
                end else begin
                    rst_cnt_s = rst_cnt_r + RST_W'(1);
                end
            end
            WAIT_LOCK: begin
                tout_cnt_s   = tout_cnt_r + TMO_W'(1);
                stable_cnt_s = lock_s ? (stable_cnt_r + STB_W'(1)) : STB_W'(0);
                if (lock_s && (stable_cnt_r == STB_W'(LOCK_STABLE_CYCLES - 1))) begin
                    state_s = HOLD;
                end else if (tout_cnt_r == TMO_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    state_s = PLL_RST;
                    retry_s = (retry_count == 4'd15) ? 4'd15 : (retry_count + 4'd1);
                end else begin
                    state_s = WAIT_LOCK;
                end
            end
            HOLD: begin
                hold_cnt_s = hold_cnt_r + HLD_W'(1);
                if (!lock_s) begin
                    state_s     = PLL_RST;
                    lock_lost_s = 1'b1;
                end else if (hold_cnt_r == HLD_W'(RESET_HOLD_CYCLES - 1)) begin
                    state_s = RUN;
                end else begin
                    state_s = HOLD;
                end
            end
            RUN: begin
                // A lock drop wins over a coincident relock request so it is never missed.
                if (!lock_s) begin
                    state_s     = PLL_RST;
                    lock_lost_s = 1'b1;
                end else if (force_relock) begin
                    state_s = PLL_RST;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = PLL_RST;
            end
        endcase
    end

    // State, counter and output registers; outputs are decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= PLL_RST;
            rst_cnt_r    <= '0;
            stable_cnt_r <= '0;
            tout_cnt_r   <= '0;
            hold_cnt_r   <= '0;
            pll_resetb   <= 1'b0;
            sys_reset    <= 1'b1;
            pll_ready    <= 1'b0;
            lock_lost    <= 1'b0;
            retry_count  <= 4'd0;
        end else begin
            state_r      <= state_s;
            rst_cnt_r    <= rst_cnt_s;
            stable_cnt_r <= stable_cnt_s;
            tout_cnt_r   <= tout_cnt_s;
            hold_cnt_r   <= hold_cnt_s;
            pll_resetb   <= (state_s != PLL_RST);
            sys_reset    <= (state_s != RUN);
            pll_ready    <= (state_s == RUN);
            lock_lost    <= lock_lost_s;
            retry_count  <= retry_s;
        end
    end

    assign seq_state = state_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench: timestamp-based reference model driven by directed and random lock/relock stimulus.
module tb_pll_reset_sequencer;

    localparam int P = 4;
    localparam int S = 8;
    localparam int T = 32;
    localparam int R = 4;

    logic       clk;
    logic       reset;
    logic       pll_lock;
    logic       force_relock;
    logic       pll_resetb;
    logic       sys_reset;
    logic       pll_ready;
    logic       lock_lost;
    logic [3:0] retry_count;
    logic [1:0] seq_state;

    int n_checks;
    int n_errors;

    // Reference model: state, cycle of state entry, cycle of last low lock sample.
    int m_state, t_ent, t_low, m_retry, mk, cur_k;
    logic m_lost, p1, p2;

    pll_reset_sequencer #(
        .PLL_RESET_CYCLES    (P),
        .LOCK_STABLE_CYCLES  (S),
        .LOCK_TIMEOUT_CYCLES (T),
        .RESET_HOLD_CYCLES   (R)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pll_lock     (pll_lock),
        .force_relock (force_relock),
        .pll_resetb   (pll_resetb),
        .sys_reset    (sys_reset),
        .pll_ready    (pll_ready),
        .lock_lost    (lock_lost),
        .retry_count  (retry_count),
        .seq_state    (seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cur_k);
        end
    endtask

    function automatic logic [9:0] dut_vec();
        return {pll_resetb, sys_reset, pll_ready, lock_lost, retry_count, seq_state};
    endfunction

    function automatic logic [9:0] exp_vec();
        logic [3:0] r;
        logic [1:0] s;
        r = m_retry[3:0];
        s = m_state[1:0];
        return {(m_state != 0), (m_state != 3), (m_state == 3), m_lost, r, s};
    endfunction

    task automatic model_reset();
        m_state = 0; t_ent = 0; t_low = 0; m_retry = 0; mk = 0;
        m_lost = 1'b0; p1 = 1'b0; p2 = 1'b0;
    endtask

    // Applies the sequencing rules at clock edge number mk.
    task automatic model_edge();
        logic ls;
        ls = p2; p2 = p1; p1 = pll_lock;
        cur_k = mk;
        case (m_state)
            0: if (mk - t_ent == P) begin m_state = 1; t_ent = mk; t_low = mk; end
            1: begin
                if (!ls) t_low = mk;
                if (mk - t_low == S) begin
                    m_state = 2; t_ent = mk;
                end else if (mk - t_ent == T) begin
                    m_state = 0; t_ent = mk;
                    if (m_retry < 15) m_retry++;
                end
            end
            2: if (!ls) begin m_state = 0; t_ent = mk; m_lost = 1'b1; end
               else if (mk - t_ent == R) begin m_state = 3; t_ent = mk; end
            3: if (!ls) begin m_state = 0; t_ent = mk; m_lost = 1'b1; end
               else if (force_relock) begin m_state = 0; t_ent = mk; end
            default: m_state = 0;
        endcase
        mk++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("outputs", dut_vec(), exp_vec());
    endtask

    // Asserts reset between edges, checks outputs before the next edge, then releases.
    task automatic do_reset();
        #2;
        reset = 1'b1; pll_lock = 1'b0; force_relock = 1'b0;
        #1;
        model_reset();
        check("reset_values", dut_vec(), exp_vec());
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cur_k = 0;
        reset = 1'b1; pll_lock = 1'b0; force_relock = 1'b0;
        model_reset();

        // Clean lock, then lock loss in RUN at cycle 40, then rerun and a relock pulse.
        do_reset();
        for (int c = 0; c < 80; c++) begin
            step();
            if (cur_k == 3)  check("resetb_low_c3", pll_resetb, 32'd0);
            if (cur_k == 4)  check("resetb_high_c4", pll_resetb, 32'd1);
            if (cur_k == 19) check("wait_c19", seq_state, 32'd1);
            if (cur_k == 20) check("hold_c20", seq_state, 32'd2);
            if (cur_k == 23) check("hold_c23", seq_state, 32'd2);
            if (cur_k == 24) begin
                check("sys_reset_c24", sys_reset, 32'd0);
                check("ready_c24", pll_ready, 32'd1);
                check("retry_c24", retry_count, 32'd0);
            end
            if (cur_k == 42) check("run_c42", seq_state, 32'd3);
            if (cur_k == 43) begin
                check("loss_sys_reset", sys_reset, 32'd1);
                check("loss_resetb", pll_resetb, 32'd0);
                check("loss_lost", lock_lost, 32'd1);
            end
            if (c == 10) pll_lock = 1'b1;
            if (c == 40) pll_lock = 1'b0;
            if (c == 46) pll_lock = 1'b1;
            force_relock = (c == 70);
        end

        // Relock request: ignored in WAIT_LOCK, honoured in RUN.
        do_reset();
        pll_lock = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (cur_k == 6) check("relock_ignored", seq_state, 32'd1);
            if (cur_k == 26) begin
                check("relock_state", seq_state, 32'd0);
                check("relock_lost", lock_lost, 32'd0);
                check("relock_retry", retry_count, 32'd0);
            end
            force_relock = (c == 5) || (c == 25);
        end

        // No lock: periodic timeouts with saturating retry count.
        do_reset();
        for (int c = 0; c < 36 * 21; c++) begin
            step();
            if (cur_k == 35) check("nolock_wait_c35", seq_state, 32'd1);
            if (cur_k == 36) begin
                check("nolock_rst_c36", seq_state, 32'd0);
                check("nolock_retry_c36", retry_count, 32'd1);
            end
        end
        check("retry_saturated", retry_count, 32'd15);
        check("nolock_sys_reset", sys_reset, 32'd1);

        // Random segments of steady, absent and glitchy lock with sporadic relock requests.
        do_reset();
        for (int seg = 0; seg < 40; seg++) begin
            int mode;
            int len;
            mode = $urandom_range(0, 2);
            len = $urandom_range(10, 90);
            for (int c = 0; c < len; c++) begin
                case (mode)
                    0: pll_lock = 1'b1;
                    1: pll_lock = 1'b0;
                    default: pll_lock = ($urandom_range(0, 7) != 0);
                endcase
                force_relock = ($urandom_range(0, 19) == 0);
                step();
            end
        end
        force_relock = 1'b0;

        // Asynchronous reset in the middle of HOLD.
        do_reset();
        pll_lock = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (seq_state == 2'd2) break;
        end
        check("reach_hold", seq_state, 32'd2);
        step();
        do_reset();
        pll_lock = 1'b1;
        for (int c = 0; c < 30; c++) step();
        check("recover_run", seq_state, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
